ula_multiciclo: RTL and testbench

Parametrised successor to the 8-bit ULA. It is an N-bit arithmetic/logic unit with a start/busy/done handshake, a full flag set, and eight opcodes. Two of those opcodes, unsigned multiply and unsigned divide, run iteratively for N cycles. Operands are captured at acceptance and results are registered, so the block sits between the register file and the result bus exactly where the 8-bit ULA sat.

---
 rtl/ula_multiciclo.sv | 207 ++++++++++++++++++++
 tb/tb_ula_multiciclo.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ula_multiciclo.sv
`default_nettype none
// ============================================================================
//  Module      : ula_multiciclo
//  Description : N-bit ALU with a start/busy/done handshake. Six single-cycle
//                opcodes and two iterative ones (shift-add MUL and restoring
//                DIV), each taking N steps. Operands are captured at
//                acceptance. Results and flags are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module ula_multiciclo #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [2:0]   opcode_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] s_o,
    output logic [N-1:0] s_hi_o,
    output logic         carry_o,
    output logic         zero_o,
    output logic         negative_o,
    output logic         overflow_o,
    output logic         busy_o,
    output logic         done_o
);

    localparam int          CW     = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_ITER = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [N-1:0]  a_q, a_d, b_q, b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  hi_q, hi_d, lo_q, lo_d;
    logic [N-1:0]  s_q, s_d, shi_q, shi_d;
    logic          c_q, c_d, z_q, z_d, n_q, n_d, v_q, v_d, done_q, done_d;

    logic [N:0]    w_add, w_sub, w_mul_sum, w_div_shift, w_div_trial;
    logic [N-1:0]  w_exec_s, w_mul_hi, w_mul_lo, w_div_hi, w_div_lo;
    logic          w_exec_c, w_exec_v, w_div_ge;

    // Single-cycle datapath for the EXEC opcodes, working on captured operands
    always_comb begin
        w_add    = {1'b0, a_q} + {1'b0, b_q};
        w_sub    = {1'b0, a_q} - {1'b0, b_q};
        w_exec_s = '0;
        w_exec_c = 1'b0;
        w_exec_v = 1'b0;
        case (op_q)
            OP_ADD: begin
                w_exec_s = w_add[N-1:0];
                w_exec_c = w_add[N];
                w_exec_v = (a_q[N-1] == b_q[N-1]) && (w_add[N-1] != a_q[N-1]);
            end
            OP_SUB: begin
                w_exec_s = w_sub[N-1:0];
                w_exec_c = w_sub[N];  // borrow out == unsigned a < b
                w_exec_v = (a_q[N-1] != b_q[N-1]) && (w_sub[N-1] != a_q[N-1]);
            end
            OP_AND:  w_exec_s = a_q & b_q;
            OP_OR:   w_exec_s = a_q | b_q;
            OP_XOR:  w_exec_s = a_q ^ b_q;
            OP_SLT:  w_exec_s = {{(N-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            default: w_exec_s = '0;
        endcase
    end

    // One iteration step: shift-add multiply (product in {hi,lo}) and
    // restoring divide (remainder in hi, quotient shifted into lo).
    // A zero divisor naturally yields an all-ones quotient and remainder = a.
    always_comb begin
        w_mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        w_mul_hi    = w_mul_sum[N:1];
        w_mul_lo    = {w_mul_sum[0], lo_q[N-1:1]};
        w_div_shift = {hi_q, lo_q[N-1]};
        w_div_trial = w_div_shift - {1'b0, b_q};
        w_div_ge    = (w_div_shift >= {1'b0, b_q});
        w_div_hi    = w_div_ge ? w_div_trial[N-1:0] : w_div_shift[N-1:0];
        w_div_lo    = {lo_q[N-2:0], w_div_ge};
    end

    // Next-state, operand capture and result write-back
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        s_d     = s_q;
        shi_d   = shi_q;
        c_d     = c_q;
        z_d     = z_q;
        n_d     = n_q;
        v_d     = v_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    op_d  = opcode_i;
                    a_d   = a_i;
                    b_d   = b_i;
                    cnt_d = '0;
                    hi_d  = '0;
                    lo_d  = a_i;
                    state_d = (opcode_i[2:1] == 2'b11) ? ST_ITER : ST_EXEC;
                end
            end
            ST_EXEC: begin
                s_d     = w_exec_s;
                shi_d   = '0;
                c_d     = w_exec_c;
                z_d     = (w_exec_s == '0);
                n_d     = w_exec_s[N-1];
                v_d     = w_exec_v;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_ITER: begin
                hi_d  = (op_q == OP_MUL) ? w_mul_hi : w_div_hi;
                lo_d  = (op_q == OP_MUL) ? w_mul_lo : w_div_lo;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    s_d   = lo_d;
                    shi_d = hi_d;
                    if (op_q == OP_MUL) begin
                        c_d = (hi_d != '0);
                        z_d = ({hi_d, lo_d} == '0);
                        n_d = hi_d[N-1];
                        v_d = 1'b0;
                    end else begin
                        c_d = 1'b0;
                        z_d = (lo_d == '0);
                        n_d = lo_d[N-1];
                        v_d = (b_q == '0);
                    end
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            s_q     <= '0;
            shi_q   <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            s_q     <= s_d;
            shi_q   <= shi_d;
            c_q     <= c_d;
            z_q     <= z_d;
            n_q     <= n_d;
            v_q     <= v_d;
            done_q  <= done_d;
        end
    end

    assign s_o        = s_q;
    assign s_hi_o     = shi_q;
    assign carry_o    = c_q;
    assign zero_o     = z_q;
    assign negative_o = n_q;
    assign overflow_o = v_q;
    assign done_o     = done_q;
    assign busy_o     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ula_multiciclo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ula_multiciclo
//  Description : Self-checking bench for ula_multiciclo (N=8): directed cases
//                plus random operations against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ula_multiciclo;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_i = 1'b0;
    logic [2:0]   opcode_i = '0;
    logic [N-1:0] a_i = '0, b_i = '0;
    logic [N-1:0] s_o, s_hi_o;
    logic         carry_o, zero_o, negative_o, overflow_o, busy_o, done_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [N-1:0] s;
        logic [N-1:0] hi;
        logic c, z, n, v;
    } res_t;

    ula_multiciclo #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .opcode_i(opcode_i),
        .a_i(a_i), .b_i(b_i), .s_o(s_o), .s_hi_o(s_hi_o),
        .carry_o(carry_o), .zero_o(zero_o), .negative_o(negative_o),
        .overflow_o(overflow_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sval(input logic [N-1:0] x);
        return int'(x) - (x[N-1] ? (1 << N) : 0);
    endfunction

    // Reference model from the arithmetic definition of each opcode
    function automatic res_t model(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        res_t r;
        int   ua, ub, sa, sb, t, lim;
        longint p;
        ua = int'(a); ub = int'(b); sa = sval(a); sb = sval(b);
        lim = 1 << N;
        r.s = '0; r.hi = '0; r.c = 0; r.v = 0;
        case (op)
            3'd0: begin t = ua + ub; r.s = N'(t % lim); r.c = (t >= lim);
                        r.v = ((sa + sb) > (lim/2 - 1)) || ((sa + sb) < -(lim/2)); end
            3'd1: begin t = ua - ub + lim; r.s = N'(t % lim); r.c = (ua < ub);
                        r.v = ((sa - sb) > (lim/2 - 1)) || ((sa - sb) < -(lim/2)); end
            3'd2: r.s = a & b;
            3'd3: r.s = a | b;
            3'd4: r.s = a ^ b;
            3'd5: r.s = (sa < sb) ? N'(1) : N'(0);
            3'd6: begin p = longint'(ua) * longint'(ub);
                        r.s = N'(p % lim); r.hi = N'(p / lim); r.c = (r.hi != 0); end
            default: begin
                if (ub == 0) begin r.s = '1; r.hi = a; r.v = 1; end
                else begin r.s = N'(ua / ub); r.hi = N'(ua % ub); end
            end
        endcase
        if (op == 3'd6) begin r.z = (r.s == 0) && (r.hi == 0); r.n = r.hi[N-1]; end
        else begin r.z = (r.s == 0); r.n = r.s[N-1]; end
        return r;
    endfunction

    task automatic check_res(input string tag, input res_t e);
        check({tag, ".s"},    32'(s_o),        32'(e.s));
        check({tag, ".s_hi"}, 32'(s_hi_o),     32'(e.hi));
        check({tag, ".c"},    32'(carry_o),    32'(e.c));
        check({tag, ".z"},    32'(zero_o),     32'(e.z));
        check({tag, ".n"},    32'(negative_o), 32'(e.n));
        check({tag, ".v"},    32'(overflow_o), 32'(e.v));
    endtask

    // Waits (sampling 1 time unit after each rising edge) for done, bounded
    task automatic wait_done(output int cycles, output int busy_cycles, input bit inject);
        cycles = 0; busy_cycles = 0;
        while (cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
            if (done_o) break;
            if (busy_o) busy_cycles++;
            if (inject && cycles == 2) begin
                start_i = 1'b1; opcode_i = 3'd0; a_i = 8'd1; b_i = 8'd1;
            end else begin
                start_i = 1'b0;
            end
        end
        start_i = 1'b0;
        if (!done_o) check("done_timeout", 32'(cycles), 32'hFFFF);
    endtask

    task automatic do_op(input string tag, input logic [2:0] op, input logic [N-1:0] a,
                         input logic [N-1:0] b, input bit inject);
        res_t e;
        int   cyc, bcyc;
        e = model(op, a, b);
        @(negedge clk);
        start_i = 1'b1; opcode_i = op; a_i = a; b_i = b;
        @(posedge clk); #1;                        // accepting edge E
        start_i = 1'b0;
        opcode_i = 3'($urandom); a_i = N'($urandom); b_i = N'($urandom);
        check({tag, ".busy_after_E"}, 32'(busy_o), 32'd1);
        wait_done(cyc, bcyc, inject);
        check({tag, ".latency"}, 32'(cyc), (op[2:1] == 2'b11) ? 32'(N) : 32'd1);
        check({tag, ".busy_cycles"}, 32'(bcyc + 1), (op[2:1] == 2'b11) ? 32'(N) : 32'd1);
        check({tag, ".busy_at_done"}, 32'(busy_o), 32'd0);
        check_res(tag, e);
        @(posedge clk); #1;
        check({tag, ".done_width"}, 32'(done_o), 32'd0);
        check_res({tag, ".hold"}, e);
    endtask

    initial begin
        int   cyc, bcyc, seen;
        res_t e;

        // Reset state
        #2;
        check("rst.s", 32'(s_o), 0);          check("rst.s_hi", 32'(s_hi_o), 0);
        check("rst.c", 32'(carry_o), 0);      check("rst.z", 32'(zero_o), 0);
        check("rst.n", 32'(negative_o), 0);   check("rst.v", 32'(overflow_o), 0);
        check("rst.busy", 32'(busy_o), 0);    check("rst.done", 32'(done_o), 0);
        @(negedge clk); rst_n = 1'b1;

        // Directed cases
        do_op("add200_100", 3'd0, 8'd200, 8'd100, 0);
        do_op("sub5_7",     3'd1, 8'd5,   8'd7,   0);
        do_op("sub80_01",   3'd1, 8'h80,  8'h01,  0);
        do_op("mul255",     3'd6, 8'hFF,  8'hFF,  1);
        do_op("div200_7",   3'd7, 8'd200, 8'd7,   0);
        do_op("div200_0",   3'd7, 8'd200, 8'd0,   0);

        // Asynchronous reset in the middle of a MUL
        @(negedge clk);
        start_i = 1'b1; opcode_i = 3'd6; a_i = 8'd99; b_i = 8'd77;
        @(posedge clk); #1; start_i = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst.s", 32'(s_o), 0);        check("midrst.s_hi", 32'(s_hi_o), 0);
        check("midrst.v", 32'(overflow_o), 0); check("midrst.n", 32'(negative_o), 0);
        check("midrst.busy", 32'(busy_o), 0);  check("midrst.done", 32'(done_o), 0);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (N + 2) begin @(posedge clk); #1; if (done_o) seen++; end
        check("midrst.no_done", 32'(seen), 0);
        do_op("and_f0_3c", 3'd2, 8'hF0, 8'h3C, 0);

        // Back-to-back SLT: second start asserted during the first done cycle
        @(negedge clk);
        start_i = 1'b1; opcode_i = 3'd5; a_i = 8'hFF; b_i = 8'h01;
        @(posedge clk); #1; start_i = 1'b0;
        wait_done(cyc, bcyc, 0);
        e = model(3'd5, 8'hFF, 8'h01);
        check_res("slt1", e);
        start_i = 1'b1; opcode_i = 3'd5; a_i = 8'h01; b_i = 8'hFF;
        @(posedge clk); #1; start_i = 1'b0;
        check("slt2.accepted", 32'(busy_o), 1);
        @(posedge clk); #1;
        check("slt2.done", 32'(done_o), 1);
        e = model(3'd5, 8'h01, 8'hFF);
        check_res("slt2", e);

        // Random operations
        for (int i = 0; i < 60; i++) begin
            logic [2:0]   op;
            logic [N-1:0] ra, rb;
            op = 3'($urandom);
            ra = N'($urandom);
            rb = ($urandom_range(0, 9) == 0) ? '0 : N'($urandom);
            do_op($sformatf("rnd%0d_op%0d", i, op), op, ra, rb, $urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
